// File: rtl/fft16_pkg.sv
// Shared constants, read-FSM state type and the radix-4 digit-reversal helper
// for the 16-point FFT input buffer.
package fft16_pkg;

    localparam int N_POINTS = 16;
    localparam int RADIX    = 4;
    localparam int GRP_W    = 2;
    localparam int ADDR_W   = 4;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_SEND = 1'b1
    } rd_state_e;

    // n = 4*n1 + n0  ->  4*n0 + n1
    function automatic logic [ADDR_W-1:0] digit_rev4(input logic [ADDR_W-1:0] addr);
        return {addr[1:0], addr[3:2]};
    endfunction

endpackage

// File: rtl/fft16_sample_bank.sv
// One 16-entry complex register file: single write port, 4-wide group read port.
// Entries 4g..4g+3 of the addressed group appear on lanes 0..3.
module fft16_sample_bank
    import fft16_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic                               clk,
    input  logic                               we_i,
    input  logic [ADDR_W-1:0]                  waddr_i,
    input  logic [WORD_SIZE-1:0]               wre_i,
    input  logic [WORD_SIZE-1:0]               wim_i,
    input  logic [GRP_W-1:0]                   grp_i,
    output logic [RADIX-1:0][WORD_SIZE-1:0]    rre_o,
    output logic [RADIX-1:0][WORD_SIZE-1:0]    rim_o
);

    // Sample storage carries no reset; validity is tracked by the full flags.
    logic [WORD_SIZE-1:0] mem_re_q [N_POINTS];
    logic [WORD_SIZE-1:0] mem_im_q [N_POINTS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_re_q[waddr_i] <= wre_i;
            mem_im_q[waddr_i] <= wim_i;
        end
    end

    always_comb begin
        rre_o = '0;
        rim_o = '0;
        for (int k = 0; k < RADIX; k++) begin
            rre_o[k] = mem_re_q[{grp_i, GRP_W'(k)}];
            rim_o[k] = mem_im_q[{grp_i, GRP_W'(k)}];
        end
    end

endmodule

// File: rtl/fft16_input_buffer.sv
// Ping-pong digit-reversing input buffer for the 16-point radix-4 FFT.
// Optional FFT_IN_SCALE_EN: samples are arithmetic-shifted right by 2 on store.
module fft16_input_buffer
    import fft16_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_SIZE-1:0]  s_re,
    input  logic [WORD_SIZE-1:0]  s_im,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [GRP_W-1:0]      m_grp,
    output logic [WORD_SIZE-1:0]  m_a_re,
    output logic [WORD_SIZE-1:0]  m_a_im,
    output logic [WORD_SIZE-1:0]  m_b_re,
    output logic [WORD_SIZE-1:0]  m_b_im,
    output logic [WORD_SIZE-1:0]  m_c_re,
    output logic [WORD_SIZE-1:0]  m_c_im,
    output logic [WORD_SIZE-1:0]  m_d_re,
    output logic [WORD_SIZE-1:0]  m_d_im,
    output logic                  m_last
);

    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        full_q, full_d;
    logic [GRP_W-1:0]  grp_q, grp_d;
    rd_state_e         state_q, state_d;

    logic                                   accept;
    logic [WORD_SIZE-1:0]                   st_re, st_im;
    logic [1:0][RADIX-1:0][WORD_SIZE-1:0]   rd_re, rd_im;

`ifdef FFT_IN_SCALE_EN
    assign st_re = WORD_SIZE'($signed(s_re) >>> 2);
    assign st_im = WORD_SIZE'($signed(s_im) >>> 2);
`else
    assign st_re = s_re;
    assign st_im = s_im;
`endif

    assign s_ready = !full_q[wr_bank_q];
    assign accept  = s_valid && s_ready && !flush;
    assign m_valid = (state_q == RD_SEND);
    assign m_grp   = grp_q;
    assign m_last  = m_valid && (grp_q == GRP_W'(RADIX-1));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft16_sample_bank #(.WORD_SIZE(WORD_SIZE)) u_bank (
            .clk     (clk),
            .we_i    (accept && (wr_bank_q == b[0])),
            .waddr_i (digit_rev4(wr_cnt_q)),
            .wre_i   (st_re),
            .wim_i   (st_im),
            .grp_i   (grp_q),
            .rre_o   (rd_re[b]),
            .rim_o   (rd_im[b])
        );
    end

    assign {m_d_re, m_c_re, m_b_re, m_a_re} = rd_re[rd_bank_q];
    assign {m_d_im, m_c_im, m_b_im, m_a_im} = rd_im[rd_bank_q];

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        grp_d     = grp_q;
        state_d   = state_q;

        if (accept) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == ADDR_W'(N_POINTS-1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end

        case (state_q)
            RD_IDLE: if (full_q[rd_bank_q]) state_d = RD_SEND;
            RD_SEND: begin
                if (m_ready) begin
                    grp_d = grp_q + 1'b1;
                    if (grp_q == GRP_W'(RADIX-1)) begin
                        // The write side only sets a bank it owns, so this
                        // clear never collides with a same-cycle set.
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = !rd_bank_q;
                        state_d           = full_q[!rd_bank_q] ? RD_SEND : RD_IDLE;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase

        if (flush) begin
            wr_cnt_d  = '0;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            full_d    = '0;
            grp_d     = '0;
            state_d   = RD_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
            grp_q     <= '0;
            state_q   <= RD_IDLE;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            grp_q     <= grp_d;
            state_q   <= state_d;
        end
    end

endmodule

// File: tb/tb_fft16_input_buffer.sv
// Directed bench for fft16_input_buffer; expectations follow FFT_IN_SCALE_EN.
module tb_fft16_input_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_re = '0, s_im = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [1:0]  m_grp;
    logic [15:0] m_a_re, m_a_im, m_b_re, m_b_im, m_c_re, m_c_im, m_d_re, m_d_im;
    logic        m_last;

    int checks = 0;
    int failures = 0;

    fft16_input_buffer #(.WORD_SIZE(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .m_valid(m_valid), .m_ready(m_ready), .m_grp(m_grp),
        .m_a_re(m_a_re), .m_a_im(m_a_im), .m_b_re(m_b_re), .m_b_im(m_b_im),
        .m_c_re(m_c_re), .m_c_im(m_c_im), .m_d_re(m_d_re), .m_d_im(m_d_im),
        .m_last(m_last)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_sc(input int v);
`ifdef FFT_IN_SCALE_EN
        return 16'(v >>> 2);
`else
        return 16'(v);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Group g of a frame whose sample n carries (off+n, -(off+n)).
    task automatic check_grp(input string tag, input int off, input int g);
        chk({tag, ".valid"}, m_valid, 1);
        chk({tag, ".grp"},   m_grp, g);
        chk({tag, ".last"},  m_last, (g == 3));
        chk({tag, ".a_re"},  m_a_re, exp_sc(off + g));
        chk({tag, ".a_im"},  m_a_im, exp_sc(-(off + g)));
        chk({tag, ".b_re"},  m_b_re, exp_sc(off + g + 4));
        chk({tag, ".b_im"},  m_b_im, exp_sc(-(off + g + 4)));
        chk({tag, ".c_re"},  m_c_re, exp_sc(off + g + 8));
        chk({tag, ".c_im"},  m_c_im, exp_sc(-(off + g + 8)));
        chk({tag, ".d_re"},  m_d_re, exp_sc(off + g + 12));
        chk({tag, ".d_im"},  m_d_im, exp_sc(-(off + g + 12)));
    endtask

    task automatic feed(input string tag, input int off, input int first, input int cnt);
        for (int i = first; i < first + cnt; i++) begin
            s_valid = 1'b1;
            s_re    = 16'(off + i);
            s_im    = 16'(-(off + i));
            chk({tag, ".s_ready"}, s_ready, 1);
            step();
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 40 && !m_valid; k++) step();
        chk({tag, ".wait_valid"}, m_valid, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int acc;
        int ngrp;
        logic [15:0] e6_re, e6_im;

        // reset state
        #3;
        chk("rst.s_ready", s_ready, 1);
        chk("rst.m_valid", m_valid, 0);
        chk("rst.m_last",  m_last, 0);
        chk("rst.m_grp",   m_grp, 0);
        do_reset();

        // 1: single frame, latency and group contents
        m_ready = 1'b1;
        feed("t1", 0, 0, 16);
        chk("t1.latency_low", m_valid, 0);
        step();
        for (int g = 0; g < 4; g++) begin
            check_grp("t1", 0, g);
            step();
        end
        chk("t1.valid_end", m_valid, 0);

        // 2: three back-to-back frames, always ready
        do_reset();
        m_ready = 1'b1;
        ngrp = 0;
        fork
            feed("t2", 0, 0, 48);
            begin
                for (int cyc = 0; cyc < 200 && ngrp < 12; cyc++) begin
                    if (m_valid) begin
                        check_grp("t2", 16 * (ngrp / 4), ngrp % 4);
                        ngrp++;
                    end
                    step();
                end
            end
        join
        chk("t2.groups", ngrp, 12);

        // 3: backpressure, 33 offered with no reader
        do_reset();
        m_ready = 1'b0;
        acc = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 33; i++) begin
            s_re = 16'(acc);
            s_im = 16'(-acc);
            if (s_ready) acc++;
            step();
        end
        s_valid = 1'b0;
        chk("t3.accepted", acc, 32);
        chk("t3.s_ready_full", s_ready, 0);
        check_grp("t3.f0", 0, 0);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("t3.pulse_grp", m_grp, 1);
        chk("t3.pulse_ready", s_ready, 0);
        m_ready = 1'b1;
        step();
        step();
        chk("t3.g3_pending_ready", s_ready, 0);
        step();
        m_ready = 1'b0;
        chk("t3.released", s_ready, 1);
        check_grp("t3.f1", 16, 0);

        // 4: m_ready toggled, groups held and taken once each
        for (int g = 0; g < 4; g++) begin
            check_grp("t4.pre", 16, g);
            m_ready = 1'b0;
            step();
            check_grp("t4.hold", 16, g);
            m_ready = 1'b1;
            step();
        end
        m_ready = 1'b0;
        chk("t4.drained", m_valid, 0);

        // 5a: async reset mid-frame discards the partial frame
        do_reset();
        m_ready = 1'b1;
        feed("t5a.part", 200, 0, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("t5a.rst_valid", m_valid, 0);
        chk("t5a.rst_ready", s_ready, 1);
        #1 rst_n = 1'b1;
        step();
        feed("t5a", 100, 0, 16);
        wait_valid("t5a");
        for (int g = 0; g < 4; g++) begin
            check_grp("t5a", 100, g);
            step();
        end

        // 5b: flush overrides a handshake and discards the partial frame
        do_reset();
        m_ready = 1'b1;
        feed("t5b.part", 300, 0, 7);
        flush = 1'b1;
        s_valid = 1'b1;
        s_re = 16'd999;
        s_im = 16'd999;
        step();
        flush = 1'b0;
        s_valid = 1'b0;
        chk("t5b.flush_valid", m_valid, 0);
        chk("t5b.flush_ready", s_ready, 1);
        feed("t5b", 100, 0, 16);
        wait_valid("t5b");
        for (int g = 0; g < 4; g++) begin
            check_grp("t5b", 100, g);
            step();
        end

        // 6: input scaling on sample 0
`ifdef FFT_IN_SCALE_EN
        e6_re = 16'hFFFE;
        e6_im = 16'h0001;
`else
        e6_re = 16'hFFFB;
        e6_im = 16'h0007;
`endif
        do_reset();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_re = 16'hFFFB;
        s_im = 16'h0007;
        step();
        feed("t6", 0, 1, 15);
        wait_valid("t6");
        chk("t6.a_re", m_a_re, e6_re);
        chk("t6.a_im", m_a_im, e6_im);
        chk("t6.b_re", m_b_re, exp_sc(4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
